seq_multiplier: RTL and testbench

//  Iterative radix-2 shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product split HI/LO.

---
 rtl/seq_multiplier.sv | 136 +++++++++++++
 tb/tb_seq_multiplier.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> {hi,lo}.
// Serves MULT (signed_m=1) and MULTU (signed_m=0). Signed operands are
// reduced to magnitudes on accept; the sign is re-applied when the result
// is written, so the datapath itself is purely unsigned.
//
// Handshake: an operation is accepted on a rising edge where start=1 and
// ready=1; x, y and signed_m are sampled only at that edge. start while
// ready=0 is dropped, never queued. busy covers RUN and DONE. done pulses
// for exactly one cycle and hi/lo are valid from that cycle until the next
// done or reset. abort cancels an operation only while in RUN; done and
// ready are never high together.
//
// Cycle numbering: the accept edge closes cycle 0, iterations close
// cycles 1..WIDTH, done is high in cycle WIDTH+1, ready again in WIDTH+2.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_m,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   x_mag;
  logic [WIDTH-1:0]   y_mag;
  logic               neg_in;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic               last_iter;

  // Operand conditioning, one shift-add step, and final sign application.
  // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct
  // magnitude, so no extra bit is needed. Negating zero yields zero.
  always_comb begin
    x_mag  = x;
    y_mag  = y;
    neg_in = 1'b0;
    if (signed_m) begin
      if (x[WIDTH-1]) x_mag = -x;
      if (y[WIDTH-1]) y_mag = -y;
      neg_in = x[WIDTH-1] ^ y[WIDTH-1];
    end
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplr[0] ? {1'b0, mcand} : '0);
    acc_next  = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
    prod      = neg ? -acc_next : acc_next;
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // abort has no meaning here; start alone decides acceptance
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
            mcand <= x_mag;
            mplr  <= y_mag;
            neg   <= neg_in;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            // Flush: drop the operation, leave hi/lo as they were
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            acc  <= acc_next;
            mplr <= mplr >> 1;
            cnt  <= cnt + 1'b1;
            if (last_iter) begin
              state     <= DONE;
              done      <= 1'b1;
              {hi, lo}  <= prod;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed WIDTH=32 vectors with hand-computed
// products, handshake/abort/reset scenarios, and WIDTH=8/16 sweeps against
// a signed/unsigned integer reference model.
module tb_seq_multiplier;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- WIDTH=32 instance ----------------
  logic        start = 1'b0, signed_m = 1'b0, abort = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic        ready, busy, done;
  logic [31:0] hi, lo;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_m(signed_m), .x(x), .y(y),
    .abort(abort), .ready(ready), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // ---------------- WIDTH=8 / WIDTH=16 instances ----------------
  logic        s8_start = 1'b0, s8_sm = 1'b0, s8_abort = 1'b0;
  logic [7:0]  s8_x = '0, s8_y = '0, s8_hi, s8_lo;
  logic        s8_ready, s8_busy, s8_done;
  logic        s16_start = 1'b0, s16_sm = 1'b0, s16_abort = 1'b0;
  logic [15:0] s16_x = '0, s16_y = '0, s16_hi, s16_lo;
  logic        s16_ready, s16_busy, s16_done;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .signed_m(s8_sm), .x(s8_x), .y(s8_y),
    .abort(s8_abort), .ready(s8_ready), .busy(s8_busy), .done(s8_done),
    .hi(s8_hi), .lo(s8_lo)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(s16_start), .signed_m(s16_sm), .x(s16_x), .y(s16_y),
    .abort(s16_abort), .ready(s16_ready), .busy(s16_busy), .done(s16_done),
    .hi(s16_hi), .lo(s16_lo)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!ready && g < 100) begin
      step();
      g++;
    end
  endtask

  // One operation on the 32-bit DUT. cyc is the cycle index in which done
  // was seen (accept edge closes cycle 0); 100 means it never came.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] rh, output logic [31:0] rl, output int cyc);
    wait_ready();
    x = a; y = b; signed_m = s; start = 1'b1;
    step();
    start = 1'b0;
    x = $urandom; y = $urandom; signed_m = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    rh = hi;
    rl = lo;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input int w);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (s) begin
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
    end
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    tests++;
    if ({ready, busy, done} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags: got ready/busy/done=%b want 100", {ready, busy, done});
    end
    tests++;
    if ({hi, lo} !== 64'h0) begin
      fails++;
      $display("FAIL reset_product: got %h want 0", {hi, lo});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_unsigned();
    logic [31:0] rh, rl;
    int cyc;
    run_op(32'd7, 32'd6, 1'b0, rh, rl, cyc);
    tests++;
    if (cyc !== 33) begin
      fails++;
      $display("FAIL unsigned_latency: got cycle %0d want 33", cyc);
    end
    tests++;
    if ({rh, rl} !== 64'h00000000_0000002A) begin
      fails++;
      $display("FAIL unsigned_7x6: got %h want 000000000000002a", {rh, rl});
    end
    step();
    tests++;
    if ({ready, done} !== 2'b10) begin
      fails++;
      $display("FAIL ready_after_done: got ready/done=%b want 10", {ready, done});
    end
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, rh, rl, cyc);
    tests++;
    if ({rh, rl} !== 64'hFFFFFFFE_00000001) begin
      fails++;
      $display("FAIL unsigned_max: got %h want fffffffe00000001", {rh, rl});
    end
    run_op(32'd7, 32'hFFFFFFFA, 1'b0, rh, rl, cyc);
    tests++;
    if ({rh, rl} !== 64'h00000006_FFFFFFD6) begin
      fails++;
      $display("FAIL unsigned_7xfffffffa: got %h want 00000006ffffffd6", {rh, rl});
    end
  endtask

  task automatic test_signed();
    logic [31:0] rh, rl;
    int cyc;
    run_op(32'hFFFFFFFE, 32'd3, 1'b1, rh, rl, cyc);
    tests++;
    if ({rh, rl} !== 64'hFFFFFFFF_FFFFFFFA) begin
      fails++;
      $display("FAIL signed_m2x3: got %h want fffffffffffffffa", {rh, rl});
    end
    run_op(32'h80000000, 32'h80000000, 1'b1, rh, rl, cyc);
    tests++;
    if ({rh, rl} !== 64'h40000000_00000000) begin
      fails++;
      $display("FAIL signed_min_sq: got %h want 4000000000000000", {rh, rl});
    end
    run_op(32'd0, 32'hFFFFFFFF, 1'b1, rh, rl, cyc);
    tests++;
    if ({rh, rl} !== 64'h0) begin
      fails++;
      $display("FAIL signed_zero: got %h want 0", {rh, rl});
    end
    run_op(32'd7, 32'hFFFFFFFA, 1'b1, rh, rl, cyc);
    tests++;
    if ({rh, rl} !== 64'hFFFFFFFF_FFFFFFD6) begin
      fails++;
      $display("FAIL signed_7xm6: got %h want ffffffffffffffd6", {rh, rl});
    end
    tests++;
    if (cyc !== 33) begin
      fails++;
      $display("FAIL signed_latency: got cycle %0d want 33", cyc);
    end
  endtask

  task automatic test_busy();
    int cyc, dn, dcyc;
    logic [31:0] dhi, dlo;
    dn = 0; dcyc = 0; dhi = '0; dlo = '0;
    wait_ready();
    x = 32'd5; y = 32'd5; signed_m = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      start = (cyc == 10);
      if (cyc == 10) x = 32'd9;
      step();
      cyc++;
      if (done) begin
        dn++;
        dcyc = cyc;
        dhi = hi;
        dlo = lo;
      end
    end
    start = 1'b0;
    tests++;
    if (dn !== 1 || dcyc !== 33) begin
      fails++;
      $display("FAIL busy_single_done: got %0d pulses last at %0d want 1 at 33", dn, dcyc);
    end
    tests++;
    if ({dhi, dlo} !== 64'h19) begin
      fails++;
      $display("FAIL busy_product: got %h want 0000000000000019", {dhi, dlo});
    end
  endtask

  task automatic test_back_to_back();
    int cyc, d1, d2;
    d1 = 0; d2 = 0;
    wait_ready();
    x = 32'd2; y = 32'd3; signed_m = 1'b0; start = 1'b1;
    step();
    cyc = 1;
    while (cyc < 34) begin
      step();
      cyc++;
      if (done) d1 = cyc;
    end
    tests++;
    if (d1 !== 33 || ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first: got done at %0d ready=%b in cycle 34 want 33 and 1", d1, ready);
    end
    step();
    cyc++;
    start = 1'b0;
    x = 32'd100;
    tests++;
    if ({ready, busy} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_reaccept: got ready/busy=%b want 01", {ready, busy});
    end
    while (!done && cyc < 120) begin
      step();
      cyc++;
    end
    d2 = cyc;
    tests++;
    if (d2 !== 67 || lo !== 32'd6) begin
      fails++;
      $display("FAIL b2b_second: got done at %0d lo=%h want 67 and 00000006", d2, lo);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rh, rl;
    int cyc, dn;
    run_op(32'd7, 32'd6, 1'b0, rh, rl, cyc);
    wait_ready();
    x = 32'd3; y = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin
      step();
      cyc++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++;
    if ({ready, busy, done} !== 3'b100) begin
      fails++;
      $display("FAIL abort_idle: got ready/busy/done=%b in cycle 6 want 100", {ready, busy, done});
    end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) dn++;
    end
    tests++;
    if (dn !== 0 || {hi, lo} !== 64'h2A) begin
      fails++;
      $display("FAIL abort_no_result: got %0d pulses hi/lo=%h want 0 and 000000000000002a", dn, {hi, lo});
    end
    // abort together with start in IDLE: the start is honoured
    x = 32'd4; y = 32'd5; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    tests++;
    if (cyc !== 33 || {hi, lo} !== 64'd20) begin
      fails++;
      $display("FAIL abort_with_start: got cycle %0d product %h want 33 and 0000000000000014", cyc, {hi, lo});
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    wait_ready();
    x = 32'd9; y = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 12) begin
      step();
      cyc++;
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({ready, busy, done} !== 3'b100 || {hi, lo} !== 64'h0) begin
      fails++;
      $display("FAIL reset_mid_op: got ready/busy/done=%b hi/lo=%h want 100 and 0",
               {ready, busy, done}, {hi, lo});
    end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic sweep8();
    int cyc;
    logic [31:0] exp_p;
    for (int i = 0; i < 1000; i++) begin
      int g = 0;
      while (!s8_ready && g < 100) begin step(); g++; end
      s8_x = 8'($urandom_range(0, 255));
      s8_y = 8'($urandom_range(0, 255));
      s8_sm = 1'($urandom_range(0, 1));
      exp_p = ref_mul({8'h0, s8_x}, {8'h0, s8_y}, s8_sm, 8);
      s8_start = 1'b1;
      step();
      s8_start = 1'b0;
      cyc = 1;
      while (!s8_done && cyc < 100) begin step(); cyc++; end
      tests++;
      if (cyc !== 9 || {16'h0, s8_hi, s8_lo} !== exp_p) begin
        fails++;
        $display("FAIL sweep8: got cycle %0d product %h want 9 and %h", cyc, {s8_hi, s8_lo}, exp_p[15:0]);
      end
    end
  endtask

  task automatic sweep16();
    int cyc;
    logic [31:0] exp_p;
    for (int i = 0; i < 1000; i++) begin
      int g = 0;
      while (!s16_ready && g < 100) begin step(); g++; end
      s16_x = 16'($urandom_range(0, 65535));
      s16_y = 16'($urandom_range(0, 65535));
      s16_sm = 1'($urandom_range(0, 1));
      exp_p = ref_mul(s16_x, s16_y, s16_sm, 16);
      s16_start = 1'b1;
      step();
      s16_start = 1'b0;
      cyc = 1;
      while (!s16_done && cyc < 100) begin step(); cyc++; end
      tests++;
      if (cyc !== 17 || {s16_hi, s16_lo} !== exp_p) begin
        fails++;
        $display("FAIL sweep16: got cycle %0d product %h want 17 and %h", cyc, {s16_hi, s16_lo}, exp_p);
      end
    end
  endtask

  task automatic test_sweep();
    fork
      sweep8();
      sweep16();
    join
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_busy();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
